// File: rtl/cpu_pkg.sv
// Shared constants and types for the MIPS fetch stage.
// The IF/ID record and next-PC select encoding live here so both fetch files agree on them.
package cpu_pkg;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc_plus4;
        logic              valid;
    } if_id_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/pc_target_gen.sv
// Next-PC candidates (sequential, branch, jump) and the redirect select.
// Purely combinational; stall/flush priority is resolved by the caller.
module pc_target_gen
    import cpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]  pc,
    input  logic [W-1:0]  pc_plus4,
    input  logic          valid,
    input  logic          branch,
    input  logic [31:0]   branch_imm,
    input  logic          jump,
    input  logic [25:0]   jump_idx,
    output logic [W-1:0]  seq,
    output logic [W-1:0]  btarget,
    output logic [W-1:0]  jtarget,
    output pc_sel_t       sel
);

    logic [W-1:0] byte_offset;

    assign byte_offset = W'(branch_imm << 2);
    assign seq         = pc + W'(4);
    assign btarget     = pc_plus4 + byte_offset;
    assign jtarget     = {pc_plus4[W-1:28], jump_idx, 2'b00};

    // Branch/jump requests from a bubble in ID are meaningless, so they only count with valid.
    always_comb begin
        sel = PC_SEQ;
        if (valid && jump) begin
            sel = PC_JUMP;
        end else if (valid && branch) begin
            sel = PC_BRANCH;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, branch/jump redirect.
// Define DELAY_SLOT_EN to keep the slot after a redirect (architectural delay slot) instead of squashing it.
module fetch_stage #(
    parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                 DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              branch_i,
    input  logic [31:0]       branch_imm_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_idx_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              valid_o
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc, pc_next, seq, btarget, jtarget;
    pc_sel_t           sel;
    if_id_t            if_id, if_id_next, fetched, bubble;

    pc_target_gen #(.W(ADDR_W)) u_targets (
        .pc         (pc),
        .pc_plus4   (if_id.pc_plus4),
        .valid      (if_id.valid),
        .branch     (branch_i),
        .branch_imm (branch_imm_i),
        .jump       (jump_i),
        .jump_idx   (jump_idx_i),
        .seq        (seq),
        .btarget    (btarget),
        .jtarget    (jtarget),
        .sel        (sel)
    );

    // Stall beats redirect, redirect beats flush; a stalled redirect simply re-presents later.
    always_comb begin
        fetched    = '{instr: imem_data_i, pc_plus4: seq, valid: 1'b1};
        bubble     = '{instr: NOP_INSTR,   pc_plus4: seq, valid: 1'b0};
        pc_next    = pc;
        if_id_next = if_id;
        if (!stall_i) begin
            if (sel != PC_SEQ) begin
                pc_next = (sel == PC_JUMP) ? jtarget : btarget;
`ifdef DELAY_SLOT_EN
                if_id_next = fetched;
`else
                if_id_next = bubble;
`endif
            end else if (flush_i) begin
                pc_next    = seq;
                if_id_next = bubble;
            end else begin
                pc_next    = seq;
                if_id_next = fetched;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc    <= RESET_PC;
            if_id <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else begin
            pc    <= pc_next;
            if_id <= if_id_next;
        end
    end

    assign imem_addr_o = pc;
    assign instr_o     = if_id.instr;
    assign pc_plus4_o  = if_id.pc_plus4;
    assign valid_o     = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns addr + 32'h1000.
// Expected values follow the DELAY_SLOT_EN setting of the build.
module tb_fetch_stage;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, branch_i, jump_i;
    logic [31:0] branch_imm_i;
    logic [25:0] jump_idx_i;
    logic [31:0] imem_addr_o, imem_data_i, instr_o, pc_plus4_o;
    logic        valid_o;

    int total = 0;
    int bad   = 0;

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .branch_i     (branch_i),
        .branch_imm_i (branch_imm_i),
        .jump_i       (jump_i),
        .jump_idx_i   (jump_idx_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .instr_o      (instr_o),
        .pc_plus4_o   (pc_plus4_o),
        .valid_o      (valid_o)
    );

    always #5 clk_i = ~clk_i;

    assign imem_data_i = imem_addr_o + 32'h1000;

    task automatic tick;
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        tick();
        tick();
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_addr: got %h want %h", imem_addr_o, 32'h0); end
        total++; if (instr_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr: got %h want %h", instr_o, 32'h0); end
        total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_pc4: got %h want %h", pc_plus4_o, 32'h0); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", valid_o); end
        rst_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL first_valid: got %b want 0", valid_o); end
        tick();
        total++; if (instr_o !== 32'h1000) begin bad++; $display("[TB] FAIL first_instr: got %h want %h", instr_o, 32'h1000); end
        total++; if (pc_plus4_o !== 32'h4) begin bad++; $display("[TB] FAIL first_pc4: got %h want %h", pc_plus4_o, 32'h4); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL first_valid1: got %b want 1", valid_o); end
        total++; if (imem_addr_o !== 32'h4) begin bad++; $display("[TB] FAIL seq_addr4: got %h want %h", imem_addr_o, 32'h4); end
        tick();
        total++; if (imem_addr_o !== 32'h8) begin bad++; $display("[TB] FAIL seq_addr8: got %h want %h", imem_addr_o, 32'h8); end
    endtask

    task automatic test_branch;
        tick();
        tick();
        total++; if (pc_plus4_o !== 32'h10) begin bad++; $display("[TB] FAIL br_pre_pc4: got %h want %h", pc_plus4_o, 32'h10); end
        branch_i = 1'b1; branch_imm_i = 32'hFFFF_FFFC;
        tick();
        branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL br_target: got %h want %h", imem_addr_o, 32'h0); end
        total++; if (valid_o !== DS) begin bad++; $display("[TB] FAIL br_slot_valid: got %b want %b", valid_o, DS); end
        total++; if (instr_o !== (DS ? 32'h1010 : 32'h0)) begin bad++; $display("[TB] FAIL br_slot_instr: got %h want %h", instr_o, (DS ? 32'h1010 : 32'h0)); end
        total++; if (pc_plus4_o !== 32'h14) begin bad++; $display("[TB] FAIL br_slot_pc4: got %h want %h", pc_plus4_o, 32'h14); end
        tick();
        total++; if (instr_o !== 32'h1000) begin bad++; $display("[TB] FAIL br_after_instr: got %h want %h", instr_o, 32'h1000); end
        total++; if (imem_addr_o !== 32'h4) begin bad++; $display("[TB] FAIL br_after_addr: got %h want %h", imem_addr_o, 32'h4); end
    endtask

    task automatic test_jump;
        // Raw 32-bit offset used only to reach a high PC region quickly.
        branch_i = 1'b1; branch_imm_i = 32'h1000_0000;
        tick();
        branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'h4000_0004) begin bad++; $display("[TB] FAIL jmp_pre_addr: got %h want %h", imem_addr_o, 32'h4000_0004); end
        tick();
        total++; if (pc_plus4_o !== 32'h4000_0008) begin bad++; $display("[TB] FAIL jmp_pre_pc4: got %h want %h", pc_plus4_o, 32'h4000_0008); end
        total++; if (instr_o !== 32'h4000_1004) begin bad++; $display("[TB] FAIL jmp_pre_instr: got %h want %h", instr_o, 32'h4000_1004); end
        jump_i = 1'b1; branch_i = 1'b1; jump_idx_i = 26'h0000040; branch_imm_i = 32'hFFFF_FFFC;
        tick();
        jump_i = 1'b0; branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'h4000_0100) begin bad++; $display("[TB] FAIL jmp_target: got %h want %h", imem_addr_o, 32'h4000_0100); end
        total++; if (valid_o !== DS) begin bad++; $display("[TB] FAIL jmp_slot_valid: got %b want %b", valid_o, DS); end
        total++; if (instr_o !== (DS ? 32'h4000_1008 : 32'h0)) begin bad++; $display("[TB] FAIL jmp_slot_instr: got %h want %h", instr_o, (DS ? 32'h4000_1008 : 32'h0)); end
        tick();
        total++; if (instr_o !== 32'h4000_1100) begin bad++; $display("[TB] FAIL jmp_after_instr: got %h want %h", instr_o, 32'h4000_1100); end
        total++; if (pc_plus4_o !== 32'h4000_0104) begin bad++; $display("[TB] FAIL jmp_after_pc4: got %h want %h", pc_plus4_o, 32'h4000_0104); end
    endtask

    task automatic test_stall;
        stall_i = 1'b1; branch_i = 1'b1; branch_imm_i = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_addr_o !== 32'h4000_0104) begin bad++; $display("[TB] FAIL stall_addr[%0d]: got %h want %h", i, imem_addr_o, 32'h4000_0104); end
            total++; if (instr_o !== 32'h4000_1100) begin bad++; $display("[TB] FAIL stall_instr[%0d]: got %h want %h", i, instr_o, 32'h4000_1100); end
            total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d]: got %b want 1", i, valid_o); end
        end
        stall_i = 1'b0;
        tick();
        branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'h4000_00F4) begin bad++; $display("[TB] FAIL stall_redirect: got %h want %h", imem_addr_o, 32'h4000_00F4); end
        total++; if (valid_o !== DS) begin bad++; $display("[TB] FAIL stall_slot_valid: got %b want %b", valid_o, DS); end
        tick();
        total++; if (instr_o !== 32'h4000_10F4) begin bad++; $display("[TB] FAIL stall_after_instr: got %h want %h", instr_o, 32'h4000_10F4); end
        total++; if (imem_addr_o !== 32'h4000_00F8) begin bad++; $display("[TB] FAIL stall_after_addr: got %h want %h", imem_addr_o, 32'h4000_00F8); end
    endtask

    task automatic test_flush;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b want 0", valid_o); end
        total++; if (instr_o !== 32'h0) begin bad++; $display("[TB] FAIL flush_instr: got %h want %h", instr_o, 32'h0); end
        total++; if (imem_addr_o !== 32'h4000_00FC) begin bad++; $display("[TB] FAIL flush_addr: got %h want %h", imem_addr_o, 32'h4000_00FC); end
        branch_i = 1'b1; branch_imm_i = 32'hFFFF_FFFC;
        tick();
        branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'h4000_0100) begin bad++; $display("[TB] FAIL ign_br_addr: got %h want %h", imem_addr_o, 32'h4000_0100); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL ign_br_valid: got %b want 1", valid_o); end
        total++; if (instr_o !== 32'h4000_10FC) begin bad++; $display("[TB] FAIL ign_br_instr: got %h want %h", instr_o, 32'h4000_10FC); end
        total++; if (pc_plus4_o !== 32'h4000_0100) begin bad++; $display("[TB] FAIL ign_br_pc4: got %h want %h", pc_plus4_o, 32'h4000_0100); end
    endtask

    task automatic test_wrap;
        // 0x4000_0100 + (0x2FFF_FFBF << 2) = 0xFFFF_FFFC
        branch_i = 1'b1; branch_imm_i = 32'h2FFF_FFBF;
        tick();
        branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pre_addr: got %h want %h", imem_addr_o, 32'hFFFF_FFFC); end
        tick();
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL wrap_addr: got %h want %h", imem_addr_o, 32'h0); end
        total++; if (instr_o !== 32'h0000_0FFC) begin bad++; $display("[TB] FAIL wrap_instr: got %h want %h", instr_o, 32'h0000_0FFC); end
        total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc4: got %h want %h", pc_plus4_o, 32'h0); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL wrap_valid: got %b want 1", valid_o); end
    endtask

    task automatic test_async_reset;
        tick();
        total++; if (imem_addr_o !== 32'h4) begin bad++; $display("[TB] FAIL ar_pre_addr: got %h want %h", imem_addr_o, 32'h4); end
        branch_i = 1'b1; branch_imm_i = 32'h0000_0100;
        #2 rst_i = 1'b0;
        #1;
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL ar_addr: got %h want %h", imem_addr_o, 32'h0); end
        total++; if (instr_o !== 32'h0) begin bad++; $display("[TB] FAIL ar_instr: got %h want %h", instr_o, 32'h0); end
        total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("[TB] FAIL ar_pc4: got %h want %h", pc_plus4_o, 32'h0); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL ar_valid: got %b want 0", valid_o); end
        #1 rst_i = 1'b1;
        tick();
        branch_i = 1'b0;
        total++; if (imem_addr_o !== 32'h4) begin bad++; $display("[TB] FAIL ar_discard_addr: got %h want %h", imem_addr_o, 32'h4); end
        total++; if (instr_o !== 32'h1000) begin bad++; $display("[TB] FAIL ar_discard_instr: got %h want %h", instr_o, 32'h1000); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL ar_discard_valid: got %b want 1", valid_o); end
    endtask

    initial begin
        rst_i        = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        branch_i     = 1'b0;
        jump_i       = 1'b0;
        branch_imm_i = 32'h0;
        jump_idx_i   = 26'h0;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the MIPS CPU.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word for decode; decode's immediate field feeds the sign extender.
- Takes back the sign-extended immediate and the jump index from ID, and computes branch/jump redirects.

Parameters:
- ADDR_W, 32, PC and address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hold PC and IF/ID register.
- flush_i  in  1  replace IF/ID contents with a bubble.
- branch_i  in  1  ID instruction is a taken branch.
- branch_imm_i  in  32  sign-extended 16-bit branch offset, in words.
- jump_i  in  1  ID instruction is J/JAL.
- jump_idx_i  in  26  J-type target index.
- imem_addr_o  out  ADDR_W  instruction-memory address; equals the PC.
- imem_data_i  in  DATA_W  instruction word; combinational read of imem_addr_o.
- instr_o  out  DATA_W  IF/ID instruction.
- pc_plus4_o  out  ADDR_W  IF/ID PC+4.
- valid_o  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc=RESET_PC; instr_o=32'h0000_0000 (NOP); pc_plus4_o=0; valid_o=0.
  - Deassertion is synchronous to the next clk_i edge.
  - Reset mid-operation discards any in-flight redirect.
- Combinational targets:
  - seq = pc+4, modulo 2^32, wraps silently.
  - btarget = pc_plus4_o + (branch_imm_i<<2), modulo 2^32.
  - jtarget = {pc_plus4_o[31:28], jump_idx_i, 2'b00}.
- Redirect qualification: redirect = valid_o & (branch_i | jump_i). Branch/jump inputs are ignored when valid_o=0.
- Per clock edge, first match wins:
  1. stall_i=1: pc and the IF/ID register hold. flush_i and redirect are ignored. A redirect re-presents after the stall.
  2. redirect: pc = jtarget if jump_i, else btarget; jump_i has priority when both are set. IF/ID <= bubble (NOP, valid_o=0), which squashes the wrong-path fetch.
  3. flush_i=1: pc = seq; IF/ID <= bubble.
  4. Otherwise: pc = seq; instr_o <= imem_data_i; pc_plus4_o <= seq; valid_o <= 1.
- Latency:
  - Instruction at address A is visible on instr_o one cycle after pc=A.
  - A taken branch costs one bubble (the squashed slot).
- A bubble drives pc_plus4_o to the squashed slot's seq; it is don't-care because valid_o=0.
- The first cycle after reset fetches RESET_PC. valid_o rises one cycle later.
- No misalignment check: all targets are word-aligned by construction, and pc[1:0] stays 2'b00.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined: MIPS architectural delay slot.
  - On redirect, IF/ID loads the fetched word normally (valid_o=1) instead of a bubble.
  - pc still loads the target.
  - flush_i still produces a bubble.
- Undefined: redirect squashes the IF slot as specified above.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants.
  - NOP_INSTR = 32'h0000_0000.
  - RESET_PC default.
  - Typedef for the IF/ID record {instr, pc_plus4, valid}.
- One combinational sub-module pc_target_gen (seq, btarget, jtarget, and next-PC mux select). Keeps the adders separate from the register logic.

Test Plan:
- Reset release, RESET_PC=0, imem returns addr+32'h1000 -> imem_addr_o sequence 0,4,8; valid_o=0 in the first cycle, then instr_o=32'h1000, pc_plus4_o=4.
- Branch with IF/ID pc_plus4_o=32'h0000_0010, branch_imm_i=32'hFFFF_FFFC (-4):
  - Next pc=32'h0000_0000.
  - The following cycle shows valid_o=0 (squash) without DELAY_SLOT_EN.
  - With DELAY_SLOT_EN, the fetched word arrives with valid_o=1.
- Jump with pc_plus4_o=32'h4000_0008, jump_idx_i=26'h0000040 -> pc=32'h4000_0100; jump_i and branch_i both set gives the jump target.
- stall_i high for 3 cycles with branch_i=1 -> pc and instr_o unchanged for 3 cycles; redirect occurs on the first unstalled edge.
- flush_i=1 with stall_i=0 -> valid_o=0, pc advances by 4. branch_i=1 while valid_o=0 -> ignored, pc advances by 4.
- Wrap and async reset:
  - pc=32'hFFFF_FFFC advancing -> pc=0.
  - rst_i pulsed low mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge.
